// File: rtl/vga_pkg.sv
// Shared VGA timing constants: 640x480 @ 60 Hz defaults, sync polarity,
// coordinate width.
package vga_pkg;

  localparam int   COORD_W         = 10;

  localparam int   VGA_CLK_DIV     = 4;

  localparam int   VGA_H_VISIBLE   = 640;
  localparam int   VGA_H_FP        = 16;
  localparam int   VGA_H_SYNC      = 96;
  localparam int   VGA_H_BP        = 48;
  localparam int   VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int   VGA_V_VISIBLE   = 480;
  localparam int   VGA_V_FP        = 10;
  localparam int   VGA_V_SYNC      = 2;
  localparam int   VGA_V_BP        = 33;
  localparam int   VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 0 = active-low sync pulses (standard for 640x480)
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/scan_counter.sv
// Wrap-at-MAX up-counter with increment enable, wrap pulse and sync reset.
// The next-state value is exported so the parent can register decodes that
// line up with the counter in the same cycle.
module scan_counter #(
  parameter int W   = 10,
  parameter int MAX = 799
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q, count_d;
  logic         wrap;

  // next value: step on inc, fold back to 0 after MAX
  always_comb begin
    wrap    = inc_i && (count_q == MAX_V);
    count_d = count_q;
    if (inc_i) count_d = wrap ? '0 : count_q + 1'b1;
  end

  // counter state
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign wrap_o    = wrap;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan timing master: pixel-tick divider, h/v scan counters, registered
// sync / blanking / boundary decodes and a free-running frame counter.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int   CLK_DIV     = VGA_CLK_DIV,
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               pix_tick,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_end,
  output logic               frame_end,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] HS_END  = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] VS_END  = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

  // a 1-bit divider still works for CLK_DIV = 1: it just sits at 0
  localparam int             DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_q;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic               h_wrap, v_wrap;
  logic [7:0]         frame_q;
  logic               hsync_q, vsync_q, video_on_q, line_end_q, frame_end_q;

  // tick is combinational so an en drop never loses a pending pixel: the
  // divider parks at DIV_MAX and the tick fires again on re-enable
  assign pix_tick = en && !rst && (div_q == DIV_MAX);

  // pixel clock divider, frozen while en is low
  always_ff @(posedge clk) begin
    if (rst)     div_q <= '0;
    else if (en) div_q <= (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
  end

  scan_counter #(.W(COORD_W), .MAX(H_TOTAL - 1)) u_h (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (pix_tick),
    .count_o   (h_q),
    .count_d_o (h_d),
    .wrap_o    (h_wrap)
  );

  scan_counter #(.W(COORD_W), .MAX(V_TOTAL - 1)) u_v (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (h_wrap),
    .count_o   (v_q),
    .count_d_o (v_d),
    .wrap_o    (v_wrap)
  );

  // frames completed, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst)         frame_q <= '0;
    else if (v_wrap) frame_q <= frame_q + 8'd1;
  end

  // decodes from next counter values so they land with h_count/v_count
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      video_on_q  <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      hsync_q     <= (h_d >= HS_BEG && h_d < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q     <= (v_d >= VS_BEG && v_d < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_q  <= (h_d < H_VIS_C) && (v_d < V_VIS_C);
      line_end_q  <= h_wrap;
      frame_end_q <= v_wrap;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_end    = line_end_q;
  assign frame_end   = frame_end_q;
  assign frame_count = frame_q;

endmodule
